// File: rtl/rotation_slice_timer.sv
// Beam-break conditioning, rotation period measurement and drift-free angular slice generation.
// Slices advance with a fractional (Bresenham) accumulator, so each revolution yields exactly ROTATIONAL_RES strobes.
module rotation_slice_timer #(
  parameter int ROTATIONAL_RES = 180,
  parameter int THETA_RES      = 27,
  parameter int LOCKOUT_CYCLES = 12000
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              ir_tripped,
  output logic [$clog2(ROTATIONAL_RES)-1:0] slice_idx,
  output logic                              slice_strobe,
  output logic [THETA_RES-1:0]              period,
  output logic                              period_valid,
  output logic                              locked,
  output logic                              overflow
);

  localparam int IDX_W = $clog2(ROTATIONAL_RES);
  localparam int ACC_W = THETA_RES + 1;
  localparam int LK_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

  localparam logic [THETA_RES-1:0] CNT_MAX  = '1;
  localparam logic [THETA_RES-1:0] RES_T    = THETA_RES'(ROTATIONAL_RES);
  localparam logic [ACC_W-1:0]     RES_A    = ACC_W'(ROTATIONAL_RES);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(ROTATIONAL_RES - 1);
  localparam logic [LK_W-1:0]      LK_LOAD  = LK_W'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED} state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic                 rise_q, rise_d;
  logic [LK_W-1:0]      lockout_q, lockout_d;
  logic [THETA_RES-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 strobe_q, strobe_d;
  logic [THETA_RES-1:0] period_q, period_d;
  logic                 pv_q, pv_d;
  logic                 locked_q, locked_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic [THETA_RES-1:0] meas;
  logic [ACC_W-1:0]     acc_step;

  always_comb begin
    sync1_d   = ir_tripped;
    sync2_d   = sync1_q;
    sync3_d   = sync2_q;
    rise_d    = sync2_q & ~sync3_q;
    accept    = rise_q && (lockout_q == '0);
    // cnt_q is cleared on the accepting edge, so the edge-to-edge distance is one more than its value
    meas      = cnt_q + THETA_RES'(1);
    acc_step  = acc_q + RES_A;

    state_d   = state_q;
    lockout_d = lockout_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    strobe_d  = 1'b0;
    period_d  = period_q;
    pv_d      = 1'b0;
    locked_d  = locked_q;
    ovf_d     = ovf_q;

    if (accept) begin
      lockout_d = LK_LOAD;
    end else if (lockout_q != '0) begin
      lockout_d = lockout_q - LK_W'(1);
    end

    if (accept) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + THETA_RES'(1);
    end

    if (accept) begin
      if (state_q != ST_IDLE && meas >= RES_T) begin
        state_d  = ST_LOCKED;
        period_d = meas;
        pv_d     = 1'b1;
        locked_d = 1'b1;
        idx_d    = '0;
        acc_d    = '0;
        strobe_d = 1'b1;
        if (state_q == ST_ACQUIRE) ovf_d = 1'b0;
      end else begin
        state_d  = ST_ACQUIRE;
        locked_d = 1'b0;
      end
    end else if (cnt_q == CNT_MAX - THETA_RES'(1)) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
      ovf_d    = 1'b1;
    end else if (state_q == ST_LOCKED && idx_q != IDX_LAST) begin
      // Last slice is held until the next edge rather than wrapping, so a slowing rotor never skips ahead
      if (acc_step >= {1'b0, period_q}) begin
        acc_d    = acc_step - {1'b0, period_q};
        idx_d    = idx_q + IDX_W'(1);
        strobe_d = 1'b1;
      end else begin
        acc_d = acc_step;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      rise_q    <= 1'b0;
      lockout_q <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      strobe_q  <= 1'b0;
      period_q  <= '0;
      pv_q      <= 1'b0;
      locked_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
      rise_q    <= rise_d;
      lockout_q <= lockout_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      strobe_q  <= strobe_d;
      period_q  <= period_d;
      pv_q      <= pv_d;
      locked_q  <= locked_d;
      ovf_q     <= ovf_d;
    end
  end

  assign slice_idx    = idx_q;
  assign slice_strobe = strobe_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign overflow     = ovf_q;

endmodule
